// File: rtl/pixel_unpack.sv
// pixel_unpack: takes R, G and B channel words in strict rotation from a shared
// 32-bit bus and emits eight 12-bit {R,G,B} nibble pixels per triplet.
// It also tracks the frame position and flags the first and last pixel.
// Optional build macro PIX_LSB_FIRST_EN: when defined, pixel 0 comes from
// bits [3:0] of each word. When undefined, pixel 0 comes from bits [31:28].
module pixel_unpack #(
  parameter int unsigned NUM_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] in_data,
  input  logic        r_rts,
  output logic        r_rtr,
  input  logic        g_rts,
  output logic        g_rtr,
  input  logic        b_rts,
  output logic        b_rtr,
  output logic [11:0] pix_data,
  output logic        pix_rts,
  input  logic        pix_rtr,
  output logic        pix_sof,
  output logic        pix_eof
);

  typedef enum logic [1:0] {
    LOAD_R,
    LOAD_G,
    LOAD_B,
    EMIT
  } state_t;

  localparam logic [18:0] LAST_PIX = 19'(NUM_PIXELS - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [18:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] r_word_q, r_word_d;
  logic [31:0] g_word_q, g_word_d;
  logic [31:0] b_word_q, b_word_d;
  logic [4:0]  nib_lsb;

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD_R;
      idx_q     <= '0;
      pix_cnt_q <= '0;
      r_word_q  <= '0;
      g_word_q  <= '0;
      b_word_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pix_cnt_q <= pix_cnt_d;
      r_word_q  <= r_word_d;
      g_word_q  <= g_word_d;
      b_word_q  <= b_word_d;
    end
  end

  // Next-state logic. A ready is decoded from state alone, so inside a
  // load state the channel's rts alone means a transfer. en overrides
  // every transfer in the same cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pix_cnt_d = pix_cnt_q;
    r_word_d  = r_word_q;
    g_word_d  = g_word_q;
    b_word_d  = b_word_q;
    if (en) begin
      state_d   = LOAD_R;
      idx_d     = '0;
      pix_cnt_d = '0;
      r_word_d  = '0;
      g_word_d  = '0;
      b_word_d  = '0;
    end else begin
      unique case (state_q)
        LOAD_R: begin
          if (r_rts) begin
            r_word_d = in_data;
            state_d  = LOAD_G;
          end
        end
        LOAD_G: begin
          if (g_rts) begin
            g_word_d = in_data;
            state_d  = LOAD_B;
          end
        end
        LOAD_B: begin
          if (b_rts) begin
            b_word_d = in_data;
            state_d  = EMIT;
          end
        end
        EMIT: begin
          if (pix_rtr) begin
            idx_d     = idx_q + 3'd1;
            pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 19'd1;
            if (idx_q == 3'd7) begin
              state_d = LOAD_R;
            end
          end
        end
        default: state_d = LOAD_R;
      endcase
    end
  end

  // Output decode from registers only, so the pixel holds under backpressure.
  // In the MSB-first build nibble idx sits at bit 4*(7-idx), and 7-idx is ~idx.
  always_comb begin
`ifdef PIX_LSB_FIRST_EN
    nib_lsb = {idx_q, 2'b00};
`else
    nib_lsb = {~idx_q, 2'b00};
`endif
    r_rtr    = (state_q == LOAD_R);
    g_rtr    = (state_q == LOAD_G);
    b_rtr    = (state_q == LOAD_B);
    pix_rts  = (state_q == EMIT);
    pix_data = '0;
    if (pix_rts) begin
      pix_data = {r_word_q[nib_lsb +: 4], g_word_q[nib_lsb +: 4], b_word_q[nib_lsb +: 4]};
    end
    pix_sof  = pix_rts && (pix_cnt_q == '0);
    pix_eof  = pix_rts && (pix_cnt_q == LAST_PIX);
  end

endmodule
